// File: rtl/pipeline_hazard_ctrl.sv
// Purpose : ID-stage interlock; per-register countdown scoreboard plus MUL/DIV occupancy FSM
// Latency : stall/bubble/issue are combinational from IF/ID and current state; stall_cnt is registered
// Backpr. : stall=1 holds PC and IF/ID; bubble=1 loads a NOP into ID/EX in the same cycle
//
// Ports:
//   clk, rst            rising-edge clock, synchronous active-high reset
//   id_valid, id_instr  IF/ID contents ([31:26] op, [25:21] rd, [20:16] rs1, [15:11] rs2)
//   stall, bubble       hazard detected this cycle (freeze front end, inject NOP)
//   issue               instruction leaves ID this cycle
//   md_busy             MUL/DIV unit occupied
//   stall_cnt           saturating count of stalled cycles
module pipeline_hazard_ctrl #(
  parameter int ALU_LAT = 3,
  parameter int MD_LAT  = 8,
  parameter int NREG    = 32,
  parameter int CNT_W   = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             id_valid,
  input  logic [31:0]      id_instr,
  output logic             stall,
  output logic             bubble,
  output logic             issue,
  output logic             md_busy,
  output logic [CNT_W-1:0] stall_cnt
);

  localparam int SB_W = $clog2(MD_LAT + 1);
  localparam logic [SB_W-1:0] L_ALU   = SB_W'(ALU_LAT);
  localparam logic [SB_W-1:0] L_MD    = SB_W'(MD_LAT);
  localparam logic [SB_W-1:0] MD_INIT = SB_W'(MD_LAT - ALU_LAT);

  typedef enum logic {S_IDLE, S_BUSY} state_t;

  // Entry 0 is never loaded, so reading it always yields "no pending write".
  logic [SB_W-1:0]  r_cnt [NREG];
  logic [SB_W-1:0]  r_md_cnt;
  logic [CNT_W-1:0] r_stall_cnt;
  state_t           r_state;

  state_t           w_state_nxt;
  logic [SB_W-1:0]  w_md_cnt_nxt;
  logic [5:0]       w_op;
  logic [4:0]       w_rd, w_rs1, w_rs2;
  logic             w_rd_a, w_rd_b, w_wr, w_md;
  logic [SB_W-1:0]  w_lat;
  logic             w_raw, w_waw, w_struct, w_haz, w_issue;
  logic [NREG-1:0]  w_wr_sel;
  logic             w_unused_instr;

  assign w_op  = id_instr[31:26];
  assign w_rd  = id_instr[25:21];
  assign w_rs1 = id_instr[20:16];
  assign w_rs2 = id_instr[15:11];
  assign w_unused_instr = |id_instr[10:0];

  // Instruction class decode; unknown opcodes fall through as NOP.
  always_comb begin
    w_rd_a = 1'b0;
    w_rd_b = 1'b0;
    w_wr   = 1'b0;
    w_md   = 1'b0;
    w_lat  = '0;
    case (w_op)
      6'd1, 6'd2, 6'd3, 6'd4, 6'd12, 6'd13: begin
        w_rd_a = 1'b1; w_rd_b = 1'b1; w_wr = 1'b1; w_lat = L_ALU;
      end
      6'd10, 6'd11: begin
        w_rd_a = 1'b1; w_rd_b = 1'b1; w_wr = 1'b1; w_md = 1'b1; w_lat = L_MD;
      end
      6'd5: begin
        w_rd_a = 1'b1; w_wr = 1'b1; w_lat = L_ALU;
      end
      6'd6: begin
        w_rd_a = 1'b1;
      end
      default: ;
    endcase
  end

  // Hazards use pre-update state, so an instruction never sees its own rd load.
  assign w_raw    = (w_rd_a && (w_rs1 != 5'd0) && (r_cnt[w_rs1] != '0)) ||
                    (w_rd_b && (w_rs2 != 5'd0) && (r_cnt[w_rs2] != '0));
  assign w_waw    = w_wr && (w_rd != 5'd0) && (r_cnt[w_rd] != '0);
  assign w_struct = w_md && md_busy;
  assign w_haz    = id_valid && (w_raw || w_waw || w_struct);
  assign w_issue  = id_valid && !w_haz;

  assign stall     = w_haz;
  assign bubble    = w_haz;
  assign issue     = w_issue;
  assign md_busy   = (r_state == S_BUSY);
  assign stall_cnt = r_stall_cnt;

  always_comb begin
    w_wr_sel = '0;
    if (w_issue && w_wr && (w_rd != 5'd0)) w_wr_sel[w_rd] = 1'b1;
  end

  // Scoreboard: a fresh load wins over the per-cycle decrement.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < NREG; i++) r_cnt[i] <= '0;
    end else begin
      for (int i = 0; i < NREG; i++) begin
        if (w_wr_sel[i])          r_cnt[i] <= w_lat;
        else if (r_cnt[i] != '0)  r_cnt[i] <= r_cnt[i] - 1'b1;
      end
    end
  end

  // MUL/DIV occupancy: BUSY holds for MD_INIT+1 cycles after the issue cycle.
  always_comb begin
    w_state_nxt  = r_state;
    w_md_cnt_nxt = r_md_cnt;
    case (r_state)
      S_IDLE: begin
        if (w_issue && w_md) begin
          w_state_nxt  = S_BUSY;
          w_md_cnt_nxt = MD_INIT;
        end
      end
      S_BUSY: begin
        if (r_md_cnt == '0) w_state_nxt  = S_IDLE;
        else                w_md_cnt_nxt = r_md_cnt - 1'b1;
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state  <= S_IDLE;
      r_md_cnt <= '0;
    end else begin
      r_state  <= w_state_nxt;
      r_md_cnt <= w_md_cnt_nxt;
    end
  end

  always_ff @(posedge clk) begin
    if (rst)                               r_stall_cnt <= '0;
    else if (w_haz && (r_stall_cnt != '1)) r_stall_cnt <= r_stall_cnt + 1'b1;
  end

endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
module tb_pipeline_hazard_ctrl;

  localparam int ALU_LAT = 3;
  localparam int MD_LAT  = 8;
  localparam int MD_HOLD = MD_LAT - ALU_LAT + 1;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        id_valid = 1'b0;
  logic [31:0] id_instr = 32'd0;

  logic        stall, bubble, issue, md_busy;
  logic [15:0] stall_cnt;
  logic        stall4, bubble4, issue4, md_busy4;
  logic [3:0]  stall_cnt4;

  pipeline_hazard_ctrl #(.ALU_LAT(ALU_LAT), .MD_LAT(MD_LAT), .NREG(32), .CNT_W(16)) dut (
    .clk(clk), .rst(rst), .id_valid(id_valid), .id_instr(id_instr),
    .stall(stall), .bubble(bubble), .issue(issue), .md_busy(md_busy), .stall_cnt(stall_cnt)
  );

  pipeline_hazard_ctrl #(.ALU_LAT(ALU_LAT), .MD_LAT(MD_LAT), .NREG(32), .CNT_W(4)) dut4 (
    .clk(clk), .rst(rst), .id_valid(id_valid), .id_instr(id_instr),
    .stall(stall4), .bubble(bubble4), .issue(issue4), .md_busy(md_busy4), .stall_cnt(stall_cnt4)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic        chk;
    logic [3:0]  flags;   // stall, bubble, issue, md_busy
    logic [15:0] c16;
    logic [3:0]  c4;
  } exp_t;

  exp_t q[$];
  exp_t mon_e;
  int   n_vec = 0;
  int   n_bad = 0;

  // Reference model: absolute-time bookkeeping instead of countdowns.
  int cyc = 0;
  int ready [32];     // first cycle at which register is readable
  int md_t  = 0;      // cycle of last MUL/DIV issue
  bit md_on = 0;
  int scnt  = 0;
  bit m_haz = 0;
  bit m_issue = 0;

  function automatic logic [31:0] enc(input int op, input int rd, input int rs1, input int rs2);
    return {op[5:0], rd[4:0], rs1[4:0], rs2[4:0], 11'd0};
  endfunction

  task automatic step(input logic v, input logic [31:0] ins, input logic r);
    exp_t e;
    int op, rd, s1, s2, lat;
    bit ua, ub, wr, md, busy, haz;
    id_valid = v; id_instr = ins; rst = r;
    op = int'(ins[31:26]); rd = int'(ins[25:21]); s1 = int'(ins[20:16]); s2 = int'(ins[15:11]);
    ua = 0; ub = 0; wr = 0; md = 0; lat = 0;
    if (op inside {1, 2, 3, 4, 12, 13}) begin ua = 1; ub = 1; wr = 1; lat = ALU_LAT; end
    else if (op inside {10, 11})        begin ua = 1; ub = 1; wr = 1; md = 1; lat = MD_LAT; end
    else if (op == 5)                   begin ua = 1; wr = 1; lat = ALU_LAT; end
    else if (op == 6)                   begin ua = 1; end
    busy = md_on && (cyc > md_t) && (cyc <= md_t + MD_HOLD);
    haz  = v && ((ua && s1 != 0 && cyc < ready[s1]) ||
                 (ub && s2 != 0 && cyc < ready[s2]) ||
                 (wr && rd != 0 && cyc < ready[rd]) ||
                 (md && busy));
    e.chk   = !r;
    e.flags = {haz, haz, v && !haz, busy};
    e.c16   = (scnt > 65535) ? 16'hFFFF : 16'(scnt);
    e.c4    = (scnt > 15) ? 4'hF : 4'(scnt);
    q.push_back(e);
    if (r) begin
      for (int i = 0; i < 32; i++) ready[i] = 0;
      md_on = 0;
      scnt  = 0;
      m_issue = 0;
    end else begin
      if (haz) scnt++;
      m_issue = v && !haz;
      if (m_issue) begin
        if (wr && rd != 0) ready[rd] = cyc + 1 + lat;
        if (md) begin md_on = 1; md_t = cyc; end
      end
    end
    m_haz = haz;
    cyc++;
    @(posedge clk);
    #1;
  endtask

  task automatic issue_hold(input logic [31:0] ins);
    for (int k = 0; k < 64; k++) begin
      step(1'b1, ins, 1'b0);
      if (m_issue) return;
    end
    n_vec++; n_bad++;
    $display("FAIL issue_hold_timeout: instr %h never issued within 64 cycles", ins);
  endtask

  task automatic chk_cnt(input string name, input logic [15:0] exp16, input logic [3:0] exp4);
    n_vec++;
    if (stall_cnt !== exp16 || stall_cnt4 !== exp4) begin
      n_bad++;
      $display("FAIL %s: stall_cnt=%0d stall_cnt4=%0d, required %0d / %0d",
               name, stall_cnt, stall_cnt4, exp16, exp4);
    end
  endtask

  task automatic do_reset();
    step(1'b0, 32'd0, 1'b1);
    step(1'b0, 32'd0, 1'b0);
  endtask

  // Monitor: one expectation per driven cycle, compared mid-cycle.
  always @(negedge clk) begin
    if (q.size() > 0) begin
      mon_e = q.pop_front();
      if (mon_e.chk) begin
        n_vec++;
        if ({stall, bubble, issue, md_busy} !== mon_e.flags ||
            stall_cnt !== mon_e.c16 || stall_cnt4 !== mon_e.c4) begin
          n_bad++;
          $display("FAIL cycle_check t=%0t: got s/b/i/md=%b cnt=%0d cnt4=%0d, required %b cnt=%0d cnt4=%0d",
                   $time, {stall, bubble, issue, md_busy}, stall_cnt, stall_cnt4,
                   mon_e.flags, mon_e.c16, mon_e.c4);
        end
      end
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation exceeded time limit");
    n_bad++;
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $fatal(1, "watchdog");
  end

  logic [5:0]  ops [13] = '{6'd0, 6'd1, 6'd2, 6'd3, 6'd4, 6'd5, 6'd6, 6'd10, 6'd11, 6'd12, 6'd13, 6'd7, 6'd63};
  logic [31:0] cur;
  logic        cur_v;

  initial begin
    for (int i = 0; i < 32; i++) ready[i] = 0;
    @(posedge clk); #1;
    step(1'b0, 32'd0, 1'b1);
    do_reset();
    chk_cnt("reset_cnt", 16'd0, 4'd0);

    // LW r1, LW r2, ADD r3,r1,r2: three stalls
    step(1'b1, enc(5, 1, 0, 0), 1'b0);
    step(1'b1, enc(5, 2, 0, 0), 1'b0);
    issue_hold(enc(1, 3, 1, 2));
    chk_cnt("lw_lw_add", 16'd3, 4'd3);

    // Independent stream: no stall
    do_reset();
    step(1'b1, enc(1, 3, 1, 2), 1'b0);
    step(1'b1, enc(2, 4, 5, 6), 1'b0);
    step(1'b1, enc(3, 7, 8, 9), 1'b0);
    chk_cnt("independent", 16'd0, 4'd0);

    // MUL then dependent SW: MD_LAT stalls
    do_reset();
    step(1'b1, enc(10, 3, 1, 2), 1'b0);
    issue_hold(enc(6, 0, 3, 0));
    chk_cnt("mul_sw", 16'd8, 4'd8);

    // Back-to-back MUL on independent registers: structural stall
    do_reset();
    step(1'b1, enc(10, 3, 1, 2), 1'b0);
    issue_hold(enc(11, 7, 1, 2));
    chk_cnt("mul_mul_struct", 16'd6, 4'd6);

    // r0 is never tracked
    do_reset();
    step(1'b1, enc(1, 0, 1, 2), 1'b0);
    step(1'b1, enc(1, 4, 0, 0), 1'b0);
    step(1'b1, enc(5, 0, 0, 0), 1'b0);
    step(1'b1, enc(6, 0, 0, 0), 1'b0);
    chk_cnt("r0_only", 16'd0, 4'd0);

    // Reset in the middle of a stall drops all pending state
    do_reset();
    step(1'b1, enc(10, 3, 1, 2), 1'b0);
    for (int k = 0; k < 3; k++) step(1'b1, enc(6, 0, 3, 0), 1'b0);
    step(1'b1, enc(6, 0, 3, 0), 1'b1);
    step(1'b1, enc(6, 0, 3, 0), 1'b0);
    step(1'b1, enc(10, 5, 3, 3), 1'b0);
    chk_cnt("reset_mid_stall", 16'd0, 4'd0);

    // 24 stall cycles: narrow counter saturates
    do_reset();
    for (int k = 0; k < 3; k++) begin
      step(1'b1, enc(10, 3, 1, 2), 1'b0);
      issue_hold(enc(6, 0, 3, 0));
    end
    chk_cnt("saturate", 16'd24, 4'd15);

    // Randomized traffic; stalled instructions are held in IF/ID
    do_reset();
    cur = 32'd0; cur_v = 1'b0;
    for (int n = 0; n < 3000; n++) begin
      if (!m_haz) begin
        cur_v = ($urandom_range(0, 3) != 0);
        cur   = enc(int'(ops[$urandom_range(0, 12)]), int'($urandom_range(0, 7)),
                    int'($urandom_range(0, 7)), int'($urandom_range(0, 7)));
      end
      step(cur_v, cur, ($urandom_range(0, 199) == 0));
    end
    step(1'b0, 32'd0, 1'b0);

    repeat (2) @(negedge clk);
    if (q.size() != 0) begin
      n_vec++; n_bad++;
      $display("FAIL queue_drain: %0d expectations left, required 0", q.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
